// File: rtl/mont_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mont_mul_scheduler
// Purpose  : Shares one Montgomery multiplier core between NUM_REQ requesters.
//            Round-robin issue with a fixed 3-cycle issue rhythm, an in-order
//            tag FIFO of issued requester IDs, and result routing back to
//            the requester that owns each result.
// Revision : 1.0 - initial release
// ============================================================================
module mont_mul_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_result,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         mm_a,
  output logic [WIDTH-1:0]         mm_b,
  output logic                     mm_taken,
  input  logic                     mm_ready_in,
  input  logic [WIDTH-1:0]         mm_result,
  input  logic                     mm_ready_out,
  output logic                     mm_given,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err
);

  localparam int               c_IDW  = $clog2(NUM_REQ);
  localparam int               c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ISS_IDLE  = 2'd0,
    ISS_PULSE = 2'd1,
    ISS_GAP   = 2'd2
  } iss_state_t;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_GIVE = 2'd1,
    RSP_HOLD = 2'd2
  } rsp_state_t;

  iss_state_t         r_iss_state, w_iss_next;
  rsp_state_t         r_rsp_state, w_rsp_next;
  logic [c_IDW-1:0]   r_rr;
  logic [c_IDW-1:0]   r_tag_mem [DEPTH];
  logic [c_AW-1:0]    r_wr, r_rd;
  logic [c_AW:0]      r_count;
  logic [c_IDW-1:0]   r_rsp_tag;

  logic               w_any;
  logic [c_IDW-1:0]   w_grant, w_cand;
  logic [NUM_REQ-1:0] w_grant_oh, w_tag_oh;
  logic               w_full, w_empty;
  logic               w_push, w_pop, w_rsp_done, w_err_set;

  assign w_full   = (r_count == c_FULL);
  assign w_empty  = (r_count == '0);
  assign inflight = r_count;

  // Round-robin pick: scan downward so the lowest offset from r_rr wins.
  always_comb begin
    w_any      = 1'b0;
    w_grant    = '0;
    w_cand     = '0;
    w_grant_oh = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = c_IDW'((int'(r_rr) + k) % NUM_REQ);
      if (req_valid[w_cand]) begin
        w_any   = 1'b1;
        w_grant = w_cand;
      end
    end
    w_grant_oh[w_grant] = 1'b1;
  end

  // Issue FSM next state: arbitrate only from IDLE, then PULSE and GAP.
  always_comb begin
    w_iss_next = r_iss_state;
    w_push     = 1'b0;
    case (r_iss_state)
      ISS_IDLE: begin
        if (mm_ready_in && w_any && !w_full) begin
          w_iss_next = ISS_PULSE;
          w_push     = 1'b1;
        end
      end
      ISS_PULSE: w_iss_next = ISS_GAP;
      ISS_GAP:   w_iss_next = ISS_IDLE;
      default:   w_iss_next = ISS_IDLE;
    endcase
  end

  // Response FSM next state: take a result only when idle and a tag exists.
  always_comb begin
    w_rsp_next = r_rsp_state;
    w_pop      = 1'b0;
    w_rsp_done = 1'b0;
    w_err_set  = 1'b0;
    w_tag_oh   = '0;
    w_tag_oh[r_rsp_tag] = 1'b1;
    case (r_rsp_state)
      RSP_IDLE: begin
        if (mm_ready_out) begin
          if (!w_empty) begin
            w_rsp_next = RSP_GIVE;
            w_pop      = 1'b1;
          end else begin
            w_err_set  = 1'b1;
          end
        end
      end
      RSP_GIVE: w_rsp_next = RSP_HOLD;
      RSP_HOLD: begin
        if (rsp_ready[r_rsp_tag]) begin
          w_rsp_next = RSP_IDLE;
          w_rsp_done = 1'b1;
        end
      end
      default: w_rsp_next = RSP_IDLE;
    endcase
  end

  // State registers for both FSMs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_state <= ISS_IDLE;
      r_rsp_state <= RSP_IDLE;
    end else begin
      r_iss_state <= w_iss_next;
      r_rsp_state <= w_rsp_next;
    end
  end

  // Issue datapath: capture granted operands, pulse handshakes, advance RR.
  always_ff @(posedge clk) begin
    if (rst) begin
      mm_a      <= '0;
      mm_b      <= '0;
      mm_taken  <= 1'b0;
      req_ready <= '0;
      r_rr      <= '0;
    end else begin
      mm_taken  <= w_push;
      req_ready <= w_push ? w_grant_oh : '0;
      if (w_push) begin
        mm_a <= req_a[int'(w_grant)*WIDTH +: WIDTH];
        mm_b <= req_b[int'(w_grant)*WIDTH +: WIDTH];
        r_rr <= (w_grant == c_IDW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
      end
    end
  end

  // Tag storage; pointers alone define validity so no reset is needed here.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr] <= w_grant;
    end
  end

  // Tag FIFO pointers and occupancy; simultaneous push/pop leaves count as is.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Response datapath: latch result and owner, present it, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_valid  <= '0;
      mm_given   <= 1'b0;
      r_rsp_tag  <= '0;
      err        <= 1'b0;
    end else begin
      mm_given <= w_pop;
      if (w_pop) begin
        rsp_result <= mm_result;
        r_rsp_tag  <= r_tag_mem[r_rd];
      end
      if (r_rsp_state == RSP_GIVE) begin
        rsp_valid <= w_tag_oh;
      end else if (w_rsp_done) begin
        rsp_valid <= '0;
      end
      if (w_err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
